dff_input_debouncer: RTL and testbench

Upstream conditioning stage for the D flip-flop `d` input. It takes an asynchronous, bouncy 1-bit level (button, external pin) and synchronises it into `clk` with two flops. It filters the level with a consecutive-sample stability counter and presents a clean level `d_clean` that drives the D_FF `d` pin directly. It also emits single-cycle rise and fall strobes for downstream edge consumers.

---
 rtl/dff_input_debouncer.sv | 108 ++++++++++
 tb/tb_dff_input_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dff_input_debouncer.sv
// rtl/dff_input_debouncer.sv - two-flop synchroniser plus stability-count debouncer with edge strobes
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-low reset
//   d_raw      unsynchronised, possibly bouncing input level
//   d_clean    debounced level, drives the D flip-flop d pin
//   rise_pulse one-cycle strobe after d_clean commits 0->1
//   fall_pulse one-cycle strobe after d_clean commits 1->0
//   busy       high while a candidate transition is being qualified
module dff_input_debouncer #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic d_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             commit;

    // Only the second synchroniser stage is ever looked at by the filter.
    // With a one-sample filter the STABLE state commits directly and WAIT
    // is never entered.
    always_comb begin
        differs = (sync2 != d_clean);
        commit  = 1'b0;
        if (differs) begin
            if (state == ST_STABLE) begin
                commit = (STABLE_CYCLES == 1);
            end else begin
                commit = (cnt == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= RESET_LEVEL;
            sync2      <= RESET_LEVEL;
            d_clean    <= RESET_LEVEL;
            cnt        <= '0;
            state      <= ST_STABLE;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1      <= d_raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (commit) begin
                d_clean    <= sync2;
                rise_pulse <= sync2;
                fall_pulse <= ~sync2;
                cnt        <= '0;
                state      <= ST_STABLE;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (differs) begin
                            cnt   <= CNT_ONE;
                            state <= ST_WAIT;
                            busy  <= 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (!differs) begin
                            // Bounce back to the committed level: abandon the candidate.
                            cnt   <= '0;
                            state <= ST_STABLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dff_input_debouncer.sv
// tb/tb_dff_input_debouncer.sv - self-checking bench for dff_input_debouncer (filter lengths 4 and 1)
module tb_dff_input_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic d_raw;

    logic dc4, rp4, fp4, bz4;
    logic dc1, rp1, fp1, bz1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .d_raw(d_raw),
        .d_clean(dc4), .rise_pulse(rp4), .fall_pulse(fp4), .busy(bz4)
    );

    dff_input_debouncer #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .d_raw(d_raw),
        .d_clean(dc1), .rise_pulse(rp1), .fall_pulse(fp1), .busy(bz1)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: d_sync is d_raw delayed by two sampling edges. A level commits
    // once the trailing N d_sync samples, all taken since the last commit,
    // disagree with the committed level. busy means a partial run exists.
    bit        rawq[$];
    bit [31:0] hist [2];
    int        age  [2];
    bit        mclean [2];
    bit        mrise  [2];
    bit        mfall  [2];
    bit        mbusy  [2];

    always @(posedge clk or negedge rst) begin
        bit ds;
        int n;
        int r;
        if (!rst) begin
            rawq = {1'b0, 1'b0};
            for (int i = 0; i < 2; i++) begin
                hist[i]   = '0;
                age[i]    = 0;
                mclean[i] = 1'b0;
                mrise[i]  = 1'b0;
                mfall[i]  = 1'b0;
                mbusy[i]  = 1'b0;
            end
        end else begin
            ds = rawq.pop_front();
            rawq.push_back(d_raw);
            for (int i = 0; i < 2; i++) begin
                n = (i == 0) ? 4 : 1;
                hist[i] = {hist[i][30:0], ds};
                if (age[i] < 1000) age[i]++;
                r = 0;
                while (r < age[i] && r < 32 && hist[i][r] != mclean[i]) r++;
                mrise[i] = 1'b0;
                mfall[i] = 1'b0;
                if (r >= n) begin
                    mrise[i]  = ~mclean[i];
                    mfall[i]  = mclean[i];
                    mclean[i] = ~mclean[i];
                    age[i]    = 0;
                    mbusy[i]  = 1'b0;
                end else begin
                    mbusy[i] = (r >= 1);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("d_clean4", dc4, mclean[0]);
        check("rise4",    rp4, mrise[0]);
        check("fall4",    fp4, mfall[0]);
        check("busy4",    bz4, mbusy[0]);
        check("d_clean1", dc1, mclean[1]);
        check("rise1",    rp1, mrise[1]);
        check("fall1",    fp1, mfall[1]);
        check("busy1",    bz1, mbusy[1]);
        check("pulse_excl4", rp4 & fp4, 1'b0);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        d_raw = v;
    endtask

    initial begin
        // Reset held with d_raw high
        d_raw = 1'b1;
        rst   = 1'b0;
        #3;
        check("rst_dclean", dc4, 1'b0);
        check("rst_busy",   bz4, 1'b0);
        #17;
        rst = 1'b1;
        edges(5);
        check("t1_edge5_dclean", dc4, 1'b0);
        edges(1);
        check("t1_edge6_dclean", dc4, 1'b1);
        check("t1_edge6_rise",   rp4, 1'b1);
        edges(1);
        check("t1_rise_gone",    rp4, 1'b0);

        // Clean fall then clean rise
        drive(1'b0);
        edges(3);
        check("t2_fall_busy", bz4, 1'b1);
        edges(3);
        check("t2_fall_dclean", dc4, 1'b0);
        check("t2_fall_pulse",  fp4, 1'b1);
        check("t2_fall_busy0",  bz4, 1'b0);
        drive(1'b1);
        edges(3);
        check("t2_rise_busy", bz4, 1'b1);
        edges(3);
        check("t2_rise_dclean", dc4, 1'b1);
        check("t2_rise_pulse",  rp4, 1'b1);
        drive(1'b0);
        edges(8);
        check("t2_back_low", dc4, 1'b0);

        // Short bounce rejected
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        edges(8);
        check("t3_bounce_dclean", dc4, 1'b0);
        check("t3_bounce_busy",   bz4, 1'b0);

        // Bounce then settle
        drive(1'b1);
        drive(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1);
        edges(10);
        check("t4_settled", dc4, 1'b1);
        drive(1'b0);
        edges(8);
        check("t4_back_low", dc4, 1'b0);

        // Reset in the middle of qualification
        drive(1'b1);
        edges(4);
        check("t5_busy_before", bz4, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_dclean", dc4, 1'b0);
        check("t5_async_busy",   bz4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        edges(5);
        check("t5_edge5_dclean", dc4, 1'b0);
        edges(1);
        check("t5_edge6_dclean", dc4, 1'b1);

        // One-sample filter: three-edge latency
        drive(1'b0);
        edges(2);
        check("t6_edge2_dclean1", dc1, 1'b1);
        edges(1);
        check("t6_edge3_dclean1", dc1, 1'b0);
        check("t6_edge3_fall1",   fp1, 1'b1);
        check("t6_busy1",         bz1, 1'b0);
        edges(6);

        // Toggle every cycle: filtered level never moves
        for (int i = 0; i < 20; i++) drive(logic'(i % 2 == 0));
        edges(1);
        check("toggle_hold", dc4, 1'b0);
        drive(1'b0);
        edges(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
